// File: rtl/ws2812_pkg.sv
// ws2812_pkg: register map, field indices, timing defaults
// and FSM encoding shared by the WS2812 chain driver.
package ws2812_pkg;

  localparam logic [8:0] OFF_CTRL   = 9'h000;
  localparam logic [8:0] OFF_STATUS = 9'h004;
  localparam logic [8:0] OFF_COUNT  = 9'h008;
  localparam logic [8:0] OFF_PIXEL  = 9'h100;

  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  localparam int PIX_W = 24;
  localparam int CNT_W = 7;

  localparam int DEF_NUM_LEDS = 8;
  localparam int DEF_T_BIT    = 125;
  localparam int DEF_T1H      = 80;
  localparam int DEF_T0H      = 40;
  localparam int DEF_T_RST    = 5000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  function automatic logic [CNT_W-1:0] clamp_count(
    input logic [CNT_W-1:0] v,
    input int               n
  );
    if (v == '0) return CNT_W'(1);
    if (int'(v) > n) return CNT_W'(n);
    return v;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: per-bit timer and high/low shaping
// for one WS2812 data bit, with a bit-end strobe.
module ws2812_bit_encoder #(
  parameter int T_BIT = 125,
  parameter int T1H   = 80,
  parameter int T0H   = 40,
  parameter int TW    = 13
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_bit,
  input  logic i_strobe,
  output logic o_level,
  output logic o_bit_end
);

  logic [TW-1:0] r_timer;
  logic          r_level;
  logic [TW-1:0] w_thr;
  logic          w_last;

  assign w_thr  = i_bit ? TW'(T1H) : TW'(T0H);
  assign w_last = r_timer == TW'(T_BIT - 1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
      r_level <= 1'b0;
    end else begin
      r_timer <= (i_strobe && !w_last) ? r_timer + TW'(1) : '0;
      r_level <= i_strobe && (r_timer < w_thr);
    end
  end

  assign o_level   = r_level;
  assign o_bit_end = i_strobe & w_last;

endmodule

// File: rtl/apb_ws2812_chain.sv
// apb_ws2812_chain: APB3 register block, pixel store and
// frame sequencer driving a WS2812 LED chain.
module apb_ws2812_chain
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T1H      = DEF_T1H,
  parameter int T0H      = DEF_T0H,
  parameter int T_RST    = DEF_T_RST
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        LED_OUT
);

  localparam int TMAX = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int TW   = $clog2(TMAX);
  localparam int PW   = $clog2(NUM_LEDS) + 1;
  localparam int IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic [8:0] w_off;
  logic [5:0] w_pidx;
  logic       w_acc;
  logic       w_wr;
  logic       w_rd;
  logic       w_hit_ctrl;
  logic       w_hit_stat;
  logic       w_hit_cnt;
  logic       w_hit_pix;
  logic       w_hit;
  logic       w_start;
  logic       w_done_clr;
  logic       w_unused;

  assign w_off      = PADDR[8:0];
  assign w_pidx     = PADDR[7:2];
  assign w_acc      = PSEL & PENABLE;
  assign w_hit_ctrl = w_off == OFF_CTRL;
  assign w_hit_stat = w_off == OFF_STATUS;
  assign w_hit_cnt  = w_off == OFF_COUNT;
  assign w_hit_pix  = PADDR[8] & (PADDR[1:0] == 2'b00)
                    & ({1'b0, w_pidx} < 7'(NUM_LEDS));
  assign w_hit      = w_hit_ctrl | w_hit_stat
                    | w_hit_cnt | w_hit_pix;
  assign w_wr       = w_acc & PWRITE & w_hit;
  assign w_rd       = w_acc & ~PWRITE;
  assign w_start    = w_wr & w_hit_ctrl & PWDATA[CTRL_START];
  assign w_done_clr = w_wr & w_hit_stat & PWDATA[STAT_DONE];
  assign w_unused   = ^{PADDR[31:9], PWDATA[31:24]};

  logic [PIX_W-1:0] r_pix [NUM_LEDS];
  logic             r_auto;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < NUM_LEDS; i++) r_pix[i] <= '0;
    end else if (w_wr & w_hit_pix) begin
      r_pix[w_pidx[IW-1:0]] <= PWDATA[PIX_W-1:0];
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_auto  <= 1'b0;
      r_count <= CNT_W'(NUM_LEDS);
    end else begin
      if (w_wr & w_hit_ctrl) r_auto <= PWDATA[CTRL_AUTO];
      if (w_wr & w_hit_cnt)
        r_count <= clamp_count(PWDATA[CNT_W-1:0], NUM_LEDS);
    end
  end

  state_t           r_state;
  logic [PIX_W-1:0] r_shreg;
  logic [4:0]       r_bit_idx;
  logic [PW-1:0]    r_pix_idx;
  logic [TW-1:0]    r_gap;
  logic             r_done;
  logic             r_led;
  logic [PW-1:0]    w_nxt_idx;
  logic             w_more;
  logic             w_shift;
  logic             w_busy;
  logic             w_level;
  logic             w_bit_end;

  assign w_nxt_idx = r_pix_idx + PW'(1);
  assign w_more    = CNT_W'(w_nxt_idx) < r_count;
  assign w_shift   = r_state == ST_SHIFT;
  assign w_busy    = r_state != ST_IDLE;

  // COUNT is re-read at every pixel boundary via w_more
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_idx <= '0;
      r_pix_idx <= '0;
      r_gap     <= '0;
      r_done    <= 1'b0;
    end else begin
      if (w_done_clr) r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_SHIFT;
            r_shreg   <= r_pix[0];
            r_bit_idx <= 5'(PIX_W - 1);
            r_pix_idx <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_bit_end) begin
            if (r_bit_idx != '0) begin
              r_shreg   <= {r_shreg[PIX_W-2:0], 1'b0};
              r_bit_idx <= r_bit_idx - 5'd1;
            end else if (w_more) begin
              r_pix_idx <= w_nxt_idx;
              r_shreg   <= r_pix[w_nxt_idx[IW-1:0]];
              r_bit_idx <= 5'(PIX_W - 1);
            end else begin
              r_state <= ST_GAP;
              r_gap   <= '0;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == TW'(T_RST - 1)) begin
            r_done <= 1'b1;
            if (r_auto) begin
              r_state   <= ST_SHIFT;
              r_shreg   <= r_pix[0];
              r_bit_idx <= 5'(PIX_W - 1);
              r_pix_idx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap <= r_gap + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ws2812_bit_encoder #(
    .T_BIT (T_BIT),
    .T1H   (T1H),
    .T0H   (T0H),
    .TW    (TW)
  ) u_enc (
    .i_clk     (PCLK),
    .i_rst_n   (PRESERN),
    .i_bit     (r_shreg[PIX_W-1]),
    .i_strobe  (w_shift),
    .o_level   (w_level),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) r_led <= 1'b0;
    else          r_led <= w_level;
  end

  assign LED_OUT = r_led;
  assign PREADY  = 1'b1;
  assign PSLVERR = w_acc & ~w_hit;

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      unique case (1'b1)
        w_hit_ctrl: PRDATA[CTRL_AUTO] = r_auto;
        w_hit_stat: begin
          PRDATA[STAT_BUSY] = w_busy;
          PRDATA[STAT_DONE] = r_done;
        end
        w_hit_cnt: PRDATA[CNT_W-1:0] = r_count;
        w_hit_pix: PRDATA[PIX_W-1:0] = r_pix[w_pidx[IW-1:0]];
        default:   PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_ws2812_chain.sv
// tb_apb_ws2812_chain: randomized APB traffic and frame capture
// checked against a behavioural WS2812 line model.
module tb_apb_ws2812_chain;

  localparam int NL   = 8;
  localparam int TB   = 25;
  localparam int T1   = 16;
  localparam int T0   = 8;
  localparam int TR   = 100;
  localparam int DBIT = 24 * TB;
  localparam int SMAX = 8000;
  localparam logic [31:0] A_CTRL = 32'h000;
  localparam logic [31:0] A_STAT = 32'h004;
  localparam logic [31:0] A_CNT  = 32'h008;
  localparam logic [31:0] A_PIX  = 32'h100;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        LED_OUT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;

  logic [23:0] m_pix [NL];
  int          m_cnt;
  logic        s_led  [SMAX];
  logic        s_busy [SMAX];
  logic        s_done [SMAX];
  logic        s_vld  [SMAX];

  apb_ws2812_chain #(
    .NUM_LEDS (NL),
    .T_BIT    (TB),
    .T1H      (T1),
    .T0H      (T0),
    .T_RST    (TR)
  ) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .LED_OUT (LED_OUT)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic apb(input logic wr_n, input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rd_d, output logic err);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr_n;
    PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rd_d = PRDATA; err = PSLVERR;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] r, output logic e);
    apb(1'b0, a, 32'h0, r, e);
  endtask

  task automatic set_pix(input int i, input logic [31:0] d);
    wr(A_PIX + 32'(4 * i), d);
    m_pix[i] = d[23:0];
  endtask

  task automatic set_cnt(input logic [31:0] d);
    wr(A_CNT, d);
    if (d[6:0] == 7'd0) m_cnt = 1;
    else if (int'(d[6:0]) > NL) m_cnt = NL;
    else m_cnt = int'(d[6:0]);
  endtask

  task automatic clr();
    for (int n = 0; n < SMAX; n++) s_vld[n] = 1'b0;
  endtask

  task automatic start(input logic [31:0] ctrl);
    clr();
    wr(A_CTRL, ctrl);
    c0 = cyc;
  endtask

  // hold a STATUS read so BUSY/DONE are seen every cycle
  task automatic mon(input int upto);
    int n;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = A_STAT;
    while (cyc - c0 < upto && cyc - c0 < SMAX - 1) begin
      @(posedge PCLK);
      #1;
      n = cyc - c0;
      s_led[n] = LED_OUT;
      s_busy[n] = PRDATA[0];
      s_done[n] = PRDATA[1];
      s_vld[n] = 1'b1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  function automatic logic exp_lvl(input int idx, input int cnt);
    int b;
    logic v;
    if (idx < 0 || idx >= cnt * DBIT) return 1'b0;
    b = idx / TB;
    v = m_pix[b / 24][23 - (b % 24)];
    return (idx % TB) < (v ? T1 : T0);
  endfunction

  task automatic chk_line(input string tag, input int upto,
                          input int cnt, input int nfr);
    int per, bad, idx;
    per = cnt * DBIT + TR;
    bad = 0;
    for (int n = 1; n <= upto; n++) begin
      if (s_vld[n]) begin
        idx = n - 2;
        if (idx >= nfr * per) idx = -1;
        else if (idx >= 0) idx = idx % per;
        if (s_led[n] !== exp_lvl(idx, cnt)) bad++;
      end
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  function automatic int first_idle(input int from);
    for (int n = from; n < SMAX; n++)
      if (s_vld[n] && !s_busy[n]) return n;
    return -1;
  endfunction

  task automatic frame(input string tag);
    int f;
    f = m_cnt * DBIT + TR;
    wr(A_STAT, 32'h2);
    start(32'h1);
    mon(f + 20);
    chk_line({tag, "_line"}, f + 20, m_cnt, 1);
    chk({tag, "_idle"}, 32'(first_idle(1)), 32'(f));
    chk({tag, "_done"}, 32'({s_done[f-1], s_done[f]}), 32'h1);
  endtask

  initial begin
    logic [31:0] r;
    logic e;
    int bad, f, p;

    for (int i = 0; i < NL; i++) m_pix[i] = '0;
    m_cnt = NL;
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;

    chk("rst_led", 32'(LED_OUT), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_slverr", 32'(PSLVERR), 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h1);
    rd(A_CTRL, r, e); chk("rst_ctrl", r, 32'h0);
    rd(A_STAT, r, e); chk("rst_stat", r, 32'h0);
    rd(A_CNT, r, e);  chk("rst_cnt", r, 32'(NL));
    bad = 0;
    for (int i = 0; i < NL; i++) begin
      rd(A_PIX + 32'(4 * i), r, e);
      if (r !== 32'h0) bad++;
    end
    chk("rst_pix", 32'(bad), 32'h0);

    for (int i = 0; i < NL; i++) set_pix(i, $urandom);
    bad = 0;
    for (int i = 0; i < NL; i++) begin
      rd(A_PIX + 32'(4 * i), r, e);
      if (r !== {8'h0, m_pix[i]} || e !== 1'b0) bad++;
    end
    chk("pix_rb", 32'(bad), 32'h0);

    set_cnt(32'd0);   rd(A_CNT, r, e); chk("cnt_zero", r, 32'd1);
    set_cnt(32'd200); rd(A_CNT, r, e); chk("cnt_big", r, 32'(NL));
    apb(1'b1, A_CNT, 32'd5, r, e);
    m_cnt = 5;
    chk("wr_prdata", r, 32'h0);
    chk("wr_err", 32'(e), 32'h0);
    rd(A_CNT, r, e); chk("cnt_mid", r, 32'd5);
    rd(A_PIX + 32'(4 * NL), r, e);
    chk("oob_rd_err", 32'(e), 32'h1);
    chk("oob_rd_data", r, 32'h0);
    apb(1'b1, A_PIX + 32'(4 * NL), 32'hFFFFFF, r, e);
    chk("oob_wr_err", 32'(e), 32'h1);
    rd(A_PIX, r, e); chk("oob_noalias", r, {8'h0, m_pix[0]});
    rd(32'h00C, r, e);
    chk("unmap_err", 32'(e), 32'h1);
    chk("unmap_data", r, 32'h0);
    rd(32'h102, r, e); chk("unalign_err", 32'(e), 32'h1);
    rd(A_PIX + 32'h4, r, e); chk("pix1_ok", 32'(e), 32'h0);

    set_pix(0, 32'hFF0000);
    set_cnt(32'd1);
    frame("one");
    bad = 0;
    for (int n = 1; n <= DBIT + TR + 20; n++) if (s_led[n]) bad++;
    chk("one_high", 32'(bad), 32'(8 * T1 + 16 * T0));
    chk("one_lat", 32'({s_led[1], s_led[2]}), 32'h1);

    set_pix(0, 32'h000001);
    set_pix(1, 32'h800000);
    set_pix(2, 32'hAAAAAA);
    set_cnt(32'd3);
    frame("three");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NL; i++) set_pix(i, $urandom);
      set_cnt($urandom_range(0, 15));
      frame("rnd");
    end

    set_pix(0, $urandom);
    set_pix(1, $urandom);
    set_cnt(32'd2);
    f = 2 * DBIT + TR;
    wr(A_STAT, 32'h2);
    start(32'h1);
    set_pix(1, $urandom);
    wr(A_CTRL, 32'h1);
    mon(f + 20);
    chk_line("mid_line", f + 20, 2, 1);
    chk("mid_norestart", 32'(first_idle(1)), 32'(f));

    set_cnt(32'd1);
    f = DBIT + TR;
    wr(A_STAT, 32'h2);
    start(32'h1);
    mon(f - 2);
    wr(A_STAT, 32'h2);
    rd(A_STAT, r, e); chk("done_set_wins", r, 32'h2);
    wr(A_STAT, 32'h2);
    rd(A_STAT, r, e); chk("done_clr", r, 32'h0);

    set_pix(0, $urandom);
    p = DBIT + TR;
    start(32'h3);
    mon(2 * p + 5);
    wr(A_CTRL, 32'h0);
    mon(3 * p + 60);
    chk_line("auto_line", 3 * p + 60, 1, 3);
    chk("auto_done1", 32'({s_done[p-1], s_done[p], s_busy[p]}),
        32'h3);
    chk("auto_idle", 32'(first_idle(1)), 32'(3 * p));

    set_cnt(32'd5);
    set_pix(0, 32'hFFFFFF);
    start(32'h3);
    mon(6);
    chk("pre_rst_led", 32'(LED_OUT), 32'h1);
    #2;
    PRESERN = 1'b0;
    #1;
    chk("rst_async_led", 32'(LED_OUT), 32'h0);
    @(negedge PCLK);
    PRESERN = 1'b1;
    for (int i = 0; i < NL; i++) m_pix[i] = '0;
    m_cnt = NL;
    rd(A_CTRL, r, e); chk("rst2_ctrl", r, 32'h0);
    rd(A_STAT, r, e); chk("rst2_stat", r, 32'h0);
    rd(A_CNT, r, e);  chk("rst2_cnt", r, 32'(NL));
    bad = 0;
    for (int i = 0; i < NL; i++) begin
      rd(A_PIX + 32'(4 * i), r, e);
      if (r !== 32'h0) bad++;
    end
    chk("rst2_pix", 32'(bad), 32'h0);
    repeat (TB) @(posedge PCLK);
    #1;
    chk("rst2_led", 32'(LED_OUT), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
